fifo_rr_write_arbiter: RTL and testbench
========================================

Name: fifo_rr_write_arbiter

Overview:
- Round-robin write arbiter that shares the single write port of the interleaved sync FIFO between NUM_REQ requesters.
- Each requester has its own valid/ready stream. The arbiter grants one requester at a time for a bounded burst and forwards its beats to the FIFO input handshake.
- Also sequences FIFO flush: accepts a flush request, drains the active burst, then drives the FIFO clear for one cycle.
- Sits directly in front of the FIFO's in_data/in_valid/in_ready/clear pins.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 8, beat width; matches the FIFO data width.
- MAX_BURST, 4, maximum beats per grant before forced rotation (>=1).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- req_data  input  NUM_REQ*DATA_WIDTH  requester data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_valid  input  NUM_REQ  per-requester valid.
- req_ready  output  NUM_REQ  per-requester ready.
- fifo_in_data  output  DATA_WIDTH  to FIFO in_data.
- fifo_in_valid  output  1  to FIFO in_valid.
- fifo_in_ready  input  1  from FIFO in_ready.
- fifo_clear  output  1  to FIFO clear; one-cycle pulse, registered.
- flush_req  input  1  single-cycle flush request.
- grant  output  NUM_REQ  one-hot current grant; all zero when not in GRANT.
- grant_id  output  $clog2(NUM_REQ)  index of the granted requester; 0 when idle.
- busy  output  1  high in GRANT or FLUSH.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - state=IDLE, last_id=NUM_REQ-1 so requester 0 has top priority.
  - beat_cnt=0, flush_pend=0.
  - grant=0, grant_id=0, fifo_in_valid=0, req_ready=0, fifo_clear=0, busy=0, fifo_in_data=0.
- States: IDLE, GRANT, FLUSH.
- IDLE:
  - If flush_req or flush_pend: go to FLUSH.
  - Else if any req_valid: pick the first valid index searching last_id+1, last_id+2, ... modulo NUM_REQ. Register it into grant/grant_id, clear beat_cnt, go to GRANT.
  - Arbitration costs exactly one cycle. No data is transferred in IDLE.
- GRANT (id = g):
  - fifo_in_data = req_data[g], fifo_in_valid = req_valid[g], req_ready[g] = fifo_in_ready. All other req_ready are 0.
  - Datapath is combinational, zero added latency.
  - Transfer = req_valid[g] & fifo_in_ready. Each transfer increments beat_cnt.
  - Release when either (a) a transfer occurs with beat_cnt==MAX_BURST-1, or (b) req_valid[g]==0 in a cycle.
  - On release: last_id<=g, grant<=0. Go to FLUSH if flush_pend or flush_req in that cycle, else IDLE.
  - FIFO full (fifo_in_ready=0) with req_valid[g]=1 holds the grant indefinitely. Beat_cnt does not advance and there is no timeout.
- flush_req while in GRANT sets flush_pend. The burst continues until its normal release. flush_req in FLUSH is ignored.
- FLUSH:
  - One cycle: fifo_clear=1, all req_ready=0, fifo_in_valid=0, flush_pend cleared.
  - Next state IDLE.
  - last_id is unchanged by flush.
- Wrap-around: the search wraps modulo NUM_REQ. With a single active requester, it is re-granted after each one-cycle IDLE gap.
- busy = (state != IDLE).
- Simultaneous events:
  - flush_req and a release in the same cycle go to FLUSH.
  - flush_req and new requests in IDLE: FLUSH wins and requests wait.
- rst asserted mid-burst: the next state is the reset state. An in-flight beat in that cycle is not guaranteed to the requester; the FIFO sees valid only as driven before the edge.
- Invariants:
  - grant is one-hot or zero.
  - At most one req_ready is high at a time.
  - fifo_in_valid is never high outside GRANT.

Test Plan:
- Reset then single requester:
  - Stimulus: rst high 5 cycles; req_valid=4'b0100 with data 0x11,0x22,0x33,0x44,0x55; fifo_in_ready=1.
  - Response: grant_id=2 one cycle after valid. Four beats 0x11..0x44 reach the FIFO on consecutive cycles. Then one IDLE cycle, re-grant to 2, and 0x55 is delivered.
- Round-robin fairness:
  - Stimulus: all four requesters continuously valid, MAX_BURST=4.
  - Response: grant order 0,1,2,3,0. Each requester gets exactly 4 beats per grant, with a one-cycle gap between grants.
- FIFO backpressure:
  - Stimulus: requester 1 granted; fifo_in_ready=0 for 10 cycles, then 1.
  - Response: grant held, req_ready[1]=0, beat_cnt unchanged. Transfers resume with no beat lost or duplicated.
- Early release:
  - Stimulus: requester 3 drops valid after 2 beats while requester 0 is valid.
  - Response: release after 2 beats, then IDLE, then grant_id=0 (search wraps from 3).
- Flush mid-burst:
  - Stimulus: flush_req pulse on beat 2 of a 4-beat burst.
  - Response: beats 3 and 4 complete. fifo_clear=1 for exactly one cycle afterwards, then IDLE. The next grant follows the pre-flush last_id.
- Sync reset mid-burst:
  - Stimulus: rst asserted during GRANT.
  - Response: next cycle grant=0, fifo_in_valid=0, busy=0. First grant after reset goes to requester 0.

Source files
------------

// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port between NUM_REQ
// valid/ready requesters, with bounded bursts and drain-then-clear flush sequencing.
module fifo_rr_write_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         fifo_in_data,
  output logic                          fifo_in_valid,
  input  logic                          fifo_in_ready,
  output logic                          fifo_clear,
  input  logic                          flush_req,
  output logic [NUM_REQ-1:0]            grant,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, GRANT, FLUSH} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [ID_W-1:0]        last_id;
  logic [ID_W-1:0]        pick_id;
  logic                   pick_vld;
  logic [CNT_W-1:0]       beat_cnt;
  logic                   flush_pend;
  logic                   cur_valid;
  logic                   xfer;
  logic                   rel;
  logic [DATA_WIDTH-1:0]  req_data_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_data_a[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign cur_valid = req_valid[grant_id];
  assign xfer      = (state == GRANT) && cur_valid && fifo_in_ready;
  assign rel       = (state == GRANT) && ((xfer && (beat_cnt == LAST_BEAT)) || !cur_valid);

  // First valid requester after last_id, wrapping modulo NUM_REQ.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      int unsigned idx;
      idx = (32'(last_id) + k) % NUM_REQ;
      if (!pick_vld && req_valid[ID_W'(idx)]) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (flush_req || flush_pend) state_nxt = FLUSH;
        else if (pick_vld)           state_nxt = GRANT;
      end
      GRANT: begin
        if (rel) state_nxt = (flush_req || flush_pend) ? FLUSH : IDLE;
      end
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Zero-latency datapath from the granted requester to the FIFO port.
  always_comb begin
    fifo_in_data  = '0;
    fifo_in_valid = 1'b0;
    req_ready     = '0;
    if (state == GRANT) begin
      fifo_in_data  = req_data_a[grant_id];
      fifo_in_valid = cur_valid;
      req_ready     = grant & {NUM_REQ{fifo_in_ready}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_id    <= ID_W'(NUM_REQ - 1);
      beat_cnt   <= '0;
      flush_pend <= 1'b0;
      grant      <= '0;
      grant_id   <= '0;
      fifo_clear <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy       <= (state_nxt != IDLE);
      fifo_clear <= (state_nxt == FLUSH);
      case (state)
        IDLE: begin
          if (state_nxt == GRANT) begin
            grant    <= NUM_REQ'(1) << pick_id;
            grant_id <= pick_id;
            beat_cnt <= '0;
          end
        end
        GRANT: begin
          if (xfer) beat_cnt <= beat_cnt + CNT_W'(1);
          if (flush_req) flush_pend <= 1'b1;
          if (rel) begin
            last_id  <= grant_id;
            grant    <= '0;
            grant_id <= '0;
          end
        end
        FLUSH:   flush_pend <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// Bench for fifo_rr_write_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a behavioural arbitration model.
module tb_fifo_rr_write_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned MB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   fifo_in_data;
  logic            fifo_in_valid;
  logic            fifo_in_ready;
  logic            fifo_clear;
  logic            flush_req;
  logic [N-1:0]    grant;
  logic [1:0]      grant_id;
  logic            busy;

  always #5 clk = ~clk;

  fifo_rr_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
    .req_ready(req_ready), .fifo_in_data(fifo_in_data), .fifo_in_valid(fifo_in_valid),
    .fifo_in_ready(fifo_in_ready), .fifo_clear(fifo_clear), .flush_req(flush_req),
    .grant(grant), .grant_id(grant_id), .busy(busy)
  );

  // stimulus controls and requester-side source queues
  bit         rst_v, rdy_v, flush_v;
  bit         en [N];
  logic [7:0] src_q [N][$];
  int         cyc;
  int         errors, checks;

  // behavioural model: owner -1 means nobody holds the port
  int m_owner, m_last, m_beats;
  bit m_flushing, m_pend, m_ok;

  // observation logs
  logic [7:0]   del_q[$];
  int           del_cyc[$];
  int           gid_log[$];
  int           burst_log[$];
  int           clr_log[$];
  int           bcnt;
  logic [N-1:0] prev_grant;
  logic [N-1:0] s_grant;
  logic         s_busy, s_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_model();
    logic [N-1:0] eg, er;
    logic [7:0]   ed;
    logic         ev;
    eg = '0; er = '0; ed = '0; ev = 1'b0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ev = req_valid[m_owner];
      ed = req_data[m_owner*DW +: DW];
      if (fifo_in_ready) er[m_owner] = 1'b1;
    end
    chk("grant",     32'(grant),         32'(eg));
    chk("grant_id",  32'(grant_id),      (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    chk("busy",      32'(busy),          32'(m_owner >= 0 || m_flushing));
    chk("clear",     32'(fifo_clear),    32'(m_flushing));
    chk("in_valid",  32'(fifo_in_valid), 32'(ev));
    chk("in_data",   32'(fifo_in_data),  32'(ed));
    chk("req_ready", 32'(req_ready),     32'(er));
  endtask

  task automatic model_next();
    if (rst_v) begin
      m_owner = -1; m_last = N - 1; m_beats = 0;
      m_flushing = 0; m_pend = 0; m_ok = 1;
    end else if (m_ok) begin
      if (m_flushing) begin
        m_flushing = 0;
        m_pend = 0;
      end else if (m_owner < 0) begin
        if (flush_v || m_pend) m_flushing = 1;
        else
          for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (m_owner < 0 && en[c] && src_q[c].size() > 0) begin
              m_owner = c;
              m_beats = 0;
            end
          end
      end else begin
        bit v, xf;
        v  = en[m_owner] && src_q[m_owner].size() > 0;
        xf = v && rdy_v;
        if (xf) m_beats++;
        if ((xf && m_beats == MB) || !v) begin
          m_last  = m_owner;
          m_owner = -1;
          if (m_pend || flush_v) m_flushing = 1;
        end else if (flush_v) m_pend = 1;
      end
    end
  endtask

  task automatic record();
    if (fifo_in_valid === 1'b1 && fifo_in_ready) begin
      del_q.push_back(fifo_in_data);
      del_cyc.push_back(cyc);
    end
    if (fifo_clear === 1'b1) clr_log.push_back(cyc);
    if (grant !== '0 && prev_grant === '0) begin
      gid_log.push_back(int'(grant_id));
      bcnt = 0;
    end
    if (grant !== '0 && fifo_in_valid === 1'b1 && fifo_in_ready) bcnt++;
    if (grant === '0 && prev_grant !== '0 && !$isunknown(prev_grant)) burst_log.push_back(bcnt);
    prev_grant = grant;
    s_grant = grant; s_busy = busy; s_valid = fifo_in_valid;
  endtask

  task automatic tick();
    logic [N-1:0] pop;
    @(negedge clk);
    rst = rst_v; fifo_in_ready = rdy_v; flush_req = flush_v;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = en[i] && (src_q[i].size() > 0);
      req_data[i*DW +: DW] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
    end
    #1;
    if (m_ok) compare_model();
    record();
    pop = req_valid & req_ready;
    model_next();
    @(posedge clk);
    for (int i = 0; i < N; i++) if (pop[i] === 1'b1) void'(src_q[i].pop_front());
    flush_v = 0;
    cyc++;
  endtask

  task automatic clear_logs();
    del_q.delete(); del_cyc.delete(); gid_log.delete(); burst_log.delete(); clr_log.delete();
  endtask

  initial begin
    int s;
    logic [7:0] exp_d [5];
    errors = 0; checks = 0; cyc = 0; m_ok = 0; prev_grant = '0; bcnt = 0;
    rst = 1; req_valid = '0; req_data = '0; fifo_in_ready = 0; flush_req = 0;
    rdy_v = 1; flush_v = 0;
    for (int i = 0; i < N; i++) en[i] = 0;

    // reset then single requester 2
    rst_v = 1;
    repeat (5) tick();
    chk("reset_busy", 32'(s_busy), 32'd0);
    chk("reset_grant", 32'(s_grant), 32'd0);
    rst_v = 0;
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44; exp_d[4] = 8'h55;
    for (int j = 0; j < 5; j++) src_q[2].push_back(exp_d[j]);
    en[2] = 1;
    clear_logs();
    s = cyc;
    repeat (12) tick();
    chk("p1_count", 32'(del_q.size()), 32'd5);
    if (del_q.size() == 5) begin
      for (int j = 0; j < 5; j++) chk("p1_data", 32'(del_q[j]), 32'(exp_d[j]));
      for (int j = 0; j < 4; j++) chk("p1_cycle", 32'(del_cyc[j]), 32'(s + 1 + j));
      chk("p1_regrant_cycle", 32'(del_cyc[4]), 32'(s + 6));
    end
    chk("p1_grants", 32'(gid_log.size()), 32'd2);
    if (gid_log.size() >= 2) begin
      chk("p1_gid0", 32'(gid_log[0]), 32'd2);
      chk("p1_gid1", 32'(gid_log[1]), 32'd2);
    end

    // reset mid-burst, then round-robin fairness with all requesters valid
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < 20; j++) src_q[i].push_back(8'((i << 5) | j));
      en[i] = 1;
    end
    repeat (3) tick();
    chk("p2_granted_before_rst", 32'(s_busy), 32'd1);
    rst_v = 1;
    tick();
    rst_v = 0;
    tick();
    chk("p2_rst_grant", 32'(s_grant), 32'd0);
    chk("p2_rst_busy", 32'(s_busy), 32'd0);
    chk("p2_rst_valid", 32'(s_valid), 32'd0);
    clear_logs();
    repeat (26) tick();
    chk("p2_grants", 32'(gid_log.size() >= 5), 32'd1);
    if (gid_log.size() >= 5) begin
      chk("p2_gid0", 32'(gid_log[0]), 32'd0);
      chk("p2_gid1", 32'(gid_log[1]), 32'd1);
      chk("p2_gid2", 32'(gid_log[2]), 32'd2);
      chk("p2_gid3", 32'(gid_log[3]), 32'd3);
      chk("p2_gid4", 32'(gid_log[4]), 32'd0);
    end
    chk("p2_bursts", 32'(burst_log.size() >= 4), 32'd1);
    for (int j = 0; j < 4 && j < burst_log.size(); j++) chk("p2_burst_len", 32'(burst_log[j]), 32'd4);

    // flush on beat 2 of a burst from requester 1
    for (int i = 0; i < N; i++) begin
      en[i] = 0;
      src_q[i].delete();
    end
    rst_v = 1;
    tick();
    rst_v = 0;
    for (int j = 0; j < 6; j++) src_q[1].push_back(8'(8'hA0 + j));
    for (int j = 0; j < 4; j++) begin
      src_q[0].push_back(8'(8'h00 + j));
      src_q[2].push_back(8'(8'hC0 + j));
    end
    en[1] = 1;
    clear_logs();
    s = cyc;
    tick(); tick();
    flush_v = 1;
    tick();
    en[0] = 1; en[2] = 1;
    repeat (8) tick();
    chk("p3_beats", 32'(del_q.size() >= 4), 32'd1);
    for (int j = 0; j < 4 && j < del_q.size(); j++) begin
      chk("p3_beat_data", 32'(del_q[j]), 32'(8'hA0 + j));
      chk("p3_beat_cycle", 32'(del_cyc[j]), 32'(s + 1 + j));
    end
    chk("p3_clear_count", 32'(clr_log.size()), 32'd1);
    if (clr_log.size() >= 1) chk("p3_clear_cycle", 32'(clr_log[0]), 32'(s + 5));
    chk("p3_grants", 32'(gid_log.size() >= 2), 32'd1);
    if (gid_log.size() >= 2) begin
      chk("p3_gid0", 32'(gid_log[0]), 32'd1);
      chk("p3_gid_after_flush", 32'(gid_log[1]), 32'd2);
    end

    // randomized traffic, backpressure windows, flushes and resets
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) == 0) en[i] = ~en[i];
        if (src_q[i].size() < 3)
          repeat ($urandom_range(1, 8)) src_q[i].push_back(8'($urandom));
      end
      rdy_v   = ($urandom_range(0, 9) < 7);
      if ((k % 300) >= 100 && (k % 300) < 112) rdy_v = 0;
      flush_v = ($urandom_range(0, 49) == 0);
      rst_v   = ($urandom_range(0, 399) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
